// File: rtl/gerador_pulsos.sv
// gerador_pulsos: pulse-train source that emits N one-cycle strobes separated by G low cycles.
// Optional macro PULSO_GAP_ALEATORIO_EN adds LFSR jitter (0..7 cycles) to every gap.
module gerador_pulsos #(
  parameter int CNT_W = 4,
  parameter int GAP_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_pulsos,
  input  logic [GAP_W-1:0] gap,
  output logic             pulso,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulsos_enviados
);

`ifdef PULSO_GAP_ALEATORIO_EN
  localparam int GC_W = GAP_W + 1;
`else
  localparam int GC_W = GAP_W;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2,
    S_FIM   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [GAP_W-1:0] g_q, g_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GC_W-1:0]  gcnt_q, gcnt_d;
  logic             pulso_q, busy_q, done_q;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [GC_W-1:0]  jitter_s;
  logic [GC_W-1:0]  gap_load_s;

`ifdef PULSO_GAP_ALEATORIO_EN
  logic [15:0] lfsr_q;

  // Free-running Fibonacci LFSR, taps 16,14,13,11
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign jitter_s = GC_W'(lfsr_q[2:0]);
`else
  assign jitter_s = '0;
`endif

  // A latched gap of zero still costs one low cycle so pulses never merge.
  assign cnt_inc_s  = cnt_q + CNT_W'(1'b1);
  assign gap_load_s = ((g_q == '0) ? GC_W'(1'b1) : GC_W'(g_q)) + jitter_s;

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    g_d     = g_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d = '0;
          if (num_pulsos != '0) begin
            n_d     = num_pulsos;
            g_d     = gap;
            state_d = S_PULSE;
          end else begin
            state_d = S_FIM;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PULSE: begin
        cnt_d = cnt_inc_s;
        if (cnt_inc_s == n_q) begin
          state_d = S_FIM;
        end else begin
          state_d = S_GAP;
          gcnt_d  = gap_load_s;
        end
      end
      S_GAP: begin
        if (gcnt_q <= GC_W'(1'b1)) begin
          state_d = S_PULSE;
        end else begin
          gcnt_d = gcnt_q - GC_W'(1'b1);
        end
      end
      S_FIM: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, operands and outputs; outputs are decoded from the next state so they stay registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      g_q     <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      pulso_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      pulso_q <= (state_d == S_PULSE);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_FIM);
    end
  end

  assign pulso           = pulso_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pulsos_enviados = cnt_q;

endmodule

// File: tb/tb_gerador_pulsos.sv
// Directed bench for gerador_pulsos: per-cycle pulso/busy/done traces compared to hand-built masks.
// Bit i of each mask is the value during the (i+1)-th cycle after the accepting edge.
module tb_gerador_pulsos;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] num_pulsos;
  logic [4:0] gap;
  logic       pulso, busy, done;
  logic [3:0] pulsos_enviados;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] pm, bm, dm;

  gerador_pulsos #(.CNT_W(4), .GAP_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .num_pulsos(num_pulsos), .gap(gap),
    .pulso(pulso), .busy(busy), .done(done), .pulsos_enviados(pulsos_enviados)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Launch a train, optionally hold start or poke start (with num_pulsos=7) at one trace index.
  task automatic run_train(input logic [3:0] n, input logic [4:0] g, input bit hold,
                           input int poke, input int cycles,
                           output logic [15:0] p, output logic [15:0] b, output logic [15:0] d);
    p = '0; b = '0; d = '0;
    @(negedge clk);
    start = 1'b1; num_pulsos = n; gap = g;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1 start = hold;
      @(negedge clk);
      p[i] = pulso; b[i] = busy; d[i] = done;
      if (i == poke) begin
        start = 1'b1; num_pulsos = 4'd7; gap = 5'd0;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; num_pulsos = 4'd0; gap = 5'd0;
    #12;
    check_eq("rst_pulso", {31'd0, pulso}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_cnt", {28'd0, pulsos_enviados}, 32'd0);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);

    // N=3 G=2: pulses at 1,4,7; done at 8; busy 1..8
    run_train(4'd3, 5'd2, 1'b0, -1, 12, pm, bm, dm);
    check_eq("n3g2_pulso", {16'd0, pm}, 32'h0049);
    check_eq("n3g2_busy", {16'd0, bm}, 32'h00FF);
    check_eq("n3g2_done", {16'd0, dm}, 32'h0080);
    check_eq("n3g2_cnt", {28'd0, pulsos_enviados}, 32'd3);

    // N=4 G=0: gap treated as 1
    run_train(4'd4, 5'd0, 1'b0, -1, 12, pm, bm, dm);
    check_eq("n4g0_pulso", {16'd0, pm}, 32'h0055);
    check_eq("n4g0_busy", {16'd0, bm}, 32'h00FF);
    check_eq("n4g0_done", {16'd0, dm}, 32'h0080);
    check_eq("n4g0_cnt", {28'd0, pulsos_enviados}, 32'd4);

    // N=0: straight to FIM, counter cleared
    run_train(4'd0, 5'd3, 1'b0, -1, 6, pm, bm, dm);
    check_eq("n0_pulso", {16'd0, pm}, 32'h0000);
    check_eq("n0_busy", {16'd0, bm}, 32'h0001);
    check_eq("n0_done", {16'd0, dm}, 32'h0001);
    check_eq("n0_cnt", {28'd0, pulsos_enviados}, 32'd0);

    // N=2 G=3 with start + num_pulsos=7 poked during the gap: ignored
    run_train(4'd2, 5'd3, 1'b0, 2, 12, pm, bm, dm);
    check_eq("ign_pulso", {16'd0, pm}, 32'h0011);
    check_eq("ign_busy", {16'd0, bm}, 32'h003F);
    check_eq("ign_done", {16'd0, dm}, 32'h0020);
    check_eq("ign_cnt", {28'd0, pulsos_enviados}, 32'd2);

    // Start held, N=1 G=5: period 3 (pulse, FIM, IDLE)
    run_train(4'd1, 5'd5, 1'b1, -1, 9, pm, bm, dm);
    check_eq("hold_pulso", {16'd0, pm}, 32'h0049);
    check_eq("hold_busy", {16'd0, bm}, 32'h00DB);
    check_eq("hold_done", {16'd0, dm}, 32'h0092);
    repeat (4) @(negedge clk);
    check_eq("hold_idle_busy", {31'd0, busy}, 32'd0);

    // N=5 G=2, reset asserted mid-cycle during the 2nd pulse
    run_train(4'd5, 5'd2, 1'b0, -1, 4, pm, bm, dm);
    check_eq("mid_pulso_before", {31'd0, pulso}, 32'd1);
    check_eq("mid_cnt_before", {28'd0, pulsos_enviados}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check_eq("mid_pulso_async", {31'd0, pulso}, 32'd0);
    check_eq("mid_busy_async", {31'd0, busy}, 32'd0);
    check_eq("mid_done_async", {31'd0, done}, 32'd0);
    check_eq("mid_cnt_async", {28'd0, pulsos_enviados}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    dm = '0; bm = '0; pm = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      dm[i] = done; bm[i] = busy; pm[i] = pulso;
    end
    check_eq("post_rst_done", {16'd0, dm}, 32'h0000);
    check_eq("post_rst_busy", {16'd0, bm}, 32'h0000);
    check_eq("post_rst_pulso", {16'd0, pm}, 32'h0000);

    // Full-scale train after reset: N=15 G=1 -> 15 pulses, 15+14+1 busy cycles
    run_train(4'd15, 5'd1, 1'b0, -1, 16, pm, bm, dm);
    check_eq("n15_pulso", {16'd0, pm}, 32'h5555);
    repeat (16) @(negedge clk);
    check_eq("n15_cnt", {28'd0, pulsos_enviados}, 32'd15);
    check_eq("n15_busy_end", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
